gray_fifo_ctrl: RTL and testbench
=================================

Name: gray_fifo_ctrl

Overview:
- Single-clock FIFO pointer and flag controller built around Gray-coded read and write pointers.
- Drives an external simple dual-port RAM (address and enable only; data bypasses this block) and generates full, empty, almost-full, almost-empty, fill level and error flags.
- Sits in front of the image line/pixel buffers of the interpolation pipelines.
- Also exports its Gray pointers so a later dual-clock variant can reuse the same pointer logic.

Parameters:
- C_ADDR_WIDTH, 4: RAM address width; FIFO depth = 2^C_ADDR_WIDTH (16 by default).
- C_AFULL_THRESH, 12: almost_full asserts when fill_level >= this value.
- C_AEMPTY_THRESH, 2: almost_empty asserts when fill_level <= this value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write request from producer.
- rd_en  in  1  read request from consumer.
- ram_wr_en  out  1  RAM write strobe; high the cycle a write is accepted.
- ram_wr_addr  out  C_ADDR_WIDTH  RAM write address.
- ram_rd_en  out  1  RAM read strobe; high the cycle a read is accepted.
- ram_rd_addr  out  C_ADDR_WIDTH  RAM read address.
- rd_valid  out  1  RAM read data valid, one cycle after ram_rd_en.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- almost_full  out  1  fill_level >= C_AFULL_THRESH.
- almost_empty  out  1  fill_level <= C_AEMPTY_THRESH.
- fill_level  out  C_ADDR_WIDTH+1  number of stored entries, 0 to 2^C_ADDR_WIDTH.
- overflow  out  1  one-cycle pulse: write requested while full.
- underflow  out  1  one-cycle pulse: read requested while empty.
- wr_ptr_gray  out  C_ADDR_WIDTH+1  registered Gray write pointer.
- rd_ptr_gray  out  C_ADDR_WIDTH+1  registered Gray read pointer.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. During reset:
  - both Gray pointers = 0; rd_valid, overflow, underflow = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, fill_level = 0.
- Reset mid-operation discards all contents immediately. There is no drain.
- Pointers:
  - Stored only in Gray form, C_ADDR_WIDTH+1 bits wide.
  - Binary value per bit: bin[i] = XOR-reduction of gray[N-1:i].
  - Increment: convert to binary, add 1 modulo 2^(C_ADDR_WIDTH+1), convert back with g = b ^ (b>>1), register.
  - RAM address = low C_ADDR_WIDTH bits of the binary pointer.
  - The extra MSB distinguishes full from empty across wrap-around.
- Accept rules, evaluated on registered state:
  - Write accepted when wr_en && !full.
  - Read accepted when rd_en && !empty.
  - On an accepted operation, ram_*_en is high combinationally and the pointer advances at the next edge.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted; fill_level unchanged.
  - Full: read accepted, write rejected (overflow pulses).
  - Empty: write accepted, read rejected (underflow pulses). No write-through bypass.
- Flags, combinational from registered pointers:
  - empty when wr_ptr_gray == rd_ptr_gray.
  - full when wr_ptr_gray equals rd_ptr_gray with its top two bits inverted.
  - fill_level = wr_bin - rd_bin modulo 2^(C_ADDR_WIDTH+1).
  - Flags therefore update the cycle after an accepted operation.
- rd_valid: registered copy of ram_rd_en, matching the 1-cycle RAM read latency.
- overflow / underflow: registered single-cycle pulses, asserted the cycle after the offending request. The pointer does not move on a rejected request.
- Wrap-around: pointers roll from 2^(C_ADDR_WIDTH+1)-1 to 0 with exactly one Gray bit changing per increment. Flags stay correct across any number of wraps.
- Gray invariant: wr_ptr_gray and rd_ptr_gray change by exactly one bit per accepted operation. Checked by assertion.
- Parameter legality: C_AEMPTY_THRESH < C_AFULL_THRESH <= 2^C_ADDR_WIDTH. Illegal values are rejected by an elaboration-time check.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, full=0, fill_level=0, pointers=0; rd_en pulse -> underflow=1 for one cycle, ram_rd_en=0.
- 16 consecutive writes from empty -> ram_wr_addr 0..15; after write 12 almost_full=1; after write 16 full=1, fill_level=16, wr_ptr_gray=5'b11000; 17th wr_en -> ram_wr_en=0, overflow pulse.
- Full FIFO, wr_en and rd_en together for 1 cycle -> read accepted at addr 0, write rejected, fill_level=15, rd_valid=1 next cycle.
- Continuous simultaneous read/write at fill_level 5 for 100 cycles -> fill_level stays 5, pointers wrap past 31->0, exactly one Gray bit toggles per cycle, no flag glitch.
- Empty FIFO, wr_en and rd_en together -> write accepted, read rejected, underflow pulse, fill_level=1, empty=0 next cycle.
- rst asserted asynchronously mid-burst at fill_level 9 -> all outputs return to reset values without waiting for a clk edge; first write after release goes to addr 0.

Source files
------------

// File: rtl/gray_fifo_ctrl_if.sv
// Handshake and RAM-control bundle for gray_fifo_ctrl.
// master: producer/consumer side. slave: the pointer/flag controller.
interface gray_fifo_ctrl_if #(
   parameter int C_ADDR_WIDTH = 4
);
   logic                    wr_en;
   logic                    rd_en;
   logic                    ram_wr_en;
   logic [C_ADDR_WIDTH-1:0] ram_wr_addr;
   logic                    ram_rd_en;
   logic [C_ADDR_WIDTH-1:0] ram_rd_addr;
   logic                    rd_valid;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic                    almost_empty;
   logic [C_ADDR_WIDTH:0]   fill_level;
   logic                    overflow;
   logic                    underflow;
   logic [C_ADDR_WIDTH:0]   wr_ptr_gray;
   logic [C_ADDR_WIDTH:0]   rd_ptr_gray;

   modport master (
      output wr_en, rd_en,
      input  ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr, rd_valid,
             full, empty, almost_full, almost_empty, fill_level,
             overflow, underflow, wr_ptr_gray, rd_ptr_gray
   );

   modport slave (
      input  wr_en, rd_en,
      output ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr, rd_valid,
             full, empty, almost_full, almost_empty, fill_level,
             overflow, underflow, wr_ptr_gray, rd_ptr_gray
   );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller with Gray-coded pointers.
// Drives address/enable of an external simple dual-port RAM; data does not
// pass through here. Pointers are held only in Gray form so the same logic
// can later be split across clock domains.
module gray_fifo_ctrl #(
   parameter int C_ADDR_WIDTH    = 4,
   parameter int C_AFULL_THRESH  = 12,
   parameter int C_AEMPTY_THRESH = 2
) (
   input logic          clk,
   input logic          rst,
   gray_fifo_ctrl_if.slave f
);
   localparam int N = C_ADDR_WIDTH + 1;

   // Full compare: write pointer equals read pointer with its top two Gray
   // bits inverted (one full lap ahead).
   localparam logic [N-1:0] FULL_MASK = {2'b11, {(N-2){1'b0}}};
   localparam logic [N-1:0] AF_T      = N'(C_AFULL_THRESH);
   localparam logic [N-1:0] AE_T      = N'(C_AEMPTY_THRESH);

   if (C_ADDR_WIDTH < 2 || C_AEMPTY_THRESH < 0 ||
       C_AEMPTY_THRESH >= C_AFULL_THRESH ||
       C_AFULL_THRESH > (1 << C_ADDR_WIDTH)) begin : g_bad_param
      $error("gray_fifo_ctrl: illegal threshold/width parameters");
   end

   if ($bits(f.ram_wr_addr) != C_ADDR_WIDTH) begin : g_bad_if
      $error("gray_fifo_ctrl: interface width does not match C_ADDR_WIDTH");
   end

   function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [N-1:0] wr_g, rd_g;
   logic [N-1:0] wr_b, rd_b;
   logic [N-1:0] wr_g_nxt, rd_g_nxt;
   logic [N-1:0] fill;
   logic         full_c, empty_c;
   logic         wr_acc, rd_acc;
   logic         rd_vld_q, ovf_q, udf_q;

   assign wr_b     = g2b(wr_g);
   assign rd_b     = g2b(rd_g);
   assign wr_g_nxt = b2g(wr_b + 1'b1);
   assign rd_g_nxt = b2g(rd_b + 1'b1);

   assign empty_c  = (wr_g == rd_g);
   assign full_c   = (wr_g == (rd_g ^ FULL_MASK));
   assign fill     = wr_b - rd_b;

   // Accepts use registered flags only; no write-through when empty.
   assign wr_acc   = f.wr_en & ~full_c;
   assign rd_acc   = f.rd_en & ~empty_c;

   // Pointer registers, read-valid stage and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_g     <= '0;
         rd_g     <= '0;
         rd_vld_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (wr_acc) wr_g <= wr_g_nxt;
         if (rd_acc) rd_g <= rd_g_nxt;
         rd_vld_q <= rd_acc;
         ovf_q    <= f.wr_en & full_c;
         udf_q    <= f.rd_en & empty_c;
      end
   end

   // Every pointer advance must flip exactly one Gray bit.
   always_comb begin
      if (wr_acc) assert ($countones(wr_g ^ wr_g_nxt) == 1);
      if (rd_acc) assert ($countones(rd_g ^ rd_g_nxt) == 1);
   end

   assign f.ram_wr_en    = wr_acc;
   assign f.ram_wr_addr  = wr_b[C_ADDR_WIDTH-1:0];
   assign f.ram_rd_en    = rd_acc;
   assign f.ram_rd_addr  = rd_b[C_ADDR_WIDTH-1:0];
   assign f.rd_valid     = rd_vld_q;
   assign f.full         = full_c;
   assign f.empty        = empty_c;
   assign f.almost_full  = (fill >= AF_T);
   assign f.almost_empty = (fill <= AE_T);
   assign f.fill_level   = fill;
   assign f.overflow     = ovf_q;
   assign f.underflow    = udf_q;
   assign f.wr_ptr_gray  = wr_g;
   assign f.rd_ptr_gray  = rd_g;
endmodule

// File: tb/tb_gray_fifo_ctrl.sv
module tb_gray_fifo_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [4:0] prev_w, prev_r, eb_w, eb_r;

   gray_fifo_ctrl_if #(.C_ADDR_WIDTH(4)) bus ();

   gray_fifo_ctrl #(
      .C_ADDR_WIDTH(4), .C_AFULL_THRESH(12), .C_AEMPTY_THRESH(2)
   ) dut (
      .clk(clk), .rst(rst), .f(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string t, input bit ok, input logic [31:0] o, input logic [31:0] e);
      checks++;
      if (!ok) begin
         errors++;
         $error("FAIL %s got %0h expected %0h", t, o, e);
      end
   endtask

   task automatic tick(input logic w, input logic r);
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      #1;
      chk("rst_empty", bus.empty === 1'b1, bus.empty, 1);
      chk("rst_aempty", bus.almost_empty === 1'b1, bus.almost_empty, 1);
      chk("rst_full", bus.full === 1'b0, bus.full, 0);
      chk("rst_afull", bus.almost_full === 1'b0, bus.almost_full, 0);
      chk("rst_fill", bus.fill_level === 5'd0, bus.fill_level, 0);
      chk("rst_wrg", bus.wr_ptr_gray === 5'd0, bus.wr_ptr_gray, 0);
      chk("rst_rdg", bus.rd_ptr_gray === 5'd0, bus.rd_ptr_gray, 0);
      chk("rst_rdv", bus.rd_valid === 1'b0, bus.rd_valid, 0);
      chk("rst_ovf", bus.overflow === 1'b0, bus.overflow, 0);
      chk("rst_udf", bus.underflow === 1'b0, bus.underflow, 0);
      @(negedge clk);
      rst = 1'b0;

      tick(1'b0, 1'b0);
      chk("idle_empty", bus.empty === 1'b1, bus.empty, 1);
      chk("idle_fill", bus.fill_level === 5'd0, bus.fill_level, 0);
      tick(1'b0, 1'b1);
      chk("udf_rden", bus.ram_rd_en === 1'b0, bus.ram_rd_en, 0);
      tick(1'b0, 1'b0);
      chk("udf_pulse", bus.underflow === 1'b1, bus.underflow, 1);
      chk("udf_rdv", bus.rd_valid === 1'b0, bus.rd_valid, 0);
      chk("udf_rdg", bus.rd_ptr_gray === 5'd0, bus.rd_ptr_gray, 0);
      tick(1'b0, 1'b0);
      chk("udf_clear", bus.underflow === 1'b0, bus.underflow, 0);

      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 1'b0);
         chk("fill_wren", bus.ram_wr_en === 1'b1, bus.ram_wr_en, 1);
         chk("fill_addr", bus.ram_wr_addr === 4'(i), bus.ram_wr_addr, i);
         chk("fill_lvl", bus.fill_level === 5'(i), bus.fill_level, i);
         chk("fill_afull", bus.almost_full === (i >= 12), bus.almost_full, (i >= 12));
         chk("fill_aempty", bus.almost_empty === (i <= 2), bus.almost_empty, (i <= 2));
         chk("fill_full", bus.full === 1'b0, bus.full, 0);
      end
      tick(1'b1, 1'b0);
      chk("full_flag", bus.full === 1'b1, bus.full, 1);
      chk("full_lvl", bus.fill_level === 5'd16, bus.fill_level, 16);
      chk("full_wrg", bus.wr_ptr_gray === 5'b11000, bus.wr_ptr_gray, 5'b11000);
      chk("full_afull", bus.almost_full === 1'b1, bus.almost_full, 1);
      chk("full_wren", bus.ram_wr_en === 1'b0, bus.ram_wr_en, 0);
      tick(1'b0, 1'b0);
      chk("ovf_pulse", bus.overflow === 1'b1, bus.overflow, 1);
      chk("ovf_wrg", bus.wr_ptr_gray === 5'b11000, bus.wr_ptr_gray, 5'b11000);
      tick(1'b0, 1'b0);
      chk("ovf_clear", bus.overflow === 1'b0, bus.overflow, 0);

      tick(1'b1, 1'b1);
      chk("fr_rden", bus.ram_rd_en === 1'b1, bus.ram_rd_en, 1);
      chk("fr_rdaddr", bus.ram_rd_addr === 4'd0, bus.ram_rd_addr, 0);
      chk("fr_wren", bus.ram_wr_en === 1'b0, bus.ram_wr_en, 0);
      tick(1'b0, 1'b0);
      chk("fr_lvl", bus.fill_level === 5'd15, bus.fill_level, 15);
      chk("fr_rdv", bus.rd_valid === 1'b1, bus.rd_valid, 1);
      chk("fr_ovf", bus.overflow === 1'b1, bus.overflow, 1);
      chk("fr_full", bus.full === 1'b0, bus.full, 0);
      tick(1'b0, 1'b0);
      chk("fr_rdv_clr", bus.rd_valid === 1'b0, bus.rd_valid, 0);

      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      eb_w = 5'd16;
      eb_r = 5'd11;
      prev_w = '0;
      prev_r = '0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b1, 1'b1);
         chk("st_lvl", bus.fill_level === 5'd5, bus.fill_level, 5);
         chk("st_empty", bus.empty === 1'b0, bus.empty, 0);
         chk("st_full", bus.full === 1'b0, bus.full, 0);
         chk("st_wrg", bus.wr_ptr_gray === gray(eb_w), bus.wr_ptr_gray, gray(eb_w));
         chk("st_rdg", bus.rd_ptr_gray === gray(eb_r), bus.rd_ptr_gray, gray(eb_r));
         chk("st_wraddr", bus.ram_wr_addr === eb_w[3:0], bus.ram_wr_addr, eb_w[3:0]);
         chk("st_rdaddr", bus.ram_rd_addr === eb_r[3:0], bus.ram_rd_addr, eb_r[3:0]);
         if (i > 0) begin
            chk("st_w1bit", $countones(bus.wr_ptr_gray ^ prev_w) == 1, bus.wr_ptr_gray ^ prev_w, 1);
            chk("st_r1bit", $countones(bus.rd_ptr_gray ^ prev_r) == 1, bus.rd_ptr_gray ^ prev_r, 1);
         end
         prev_w = bus.wr_ptr_gray;
         prev_r = bus.rd_ptr_gray;
         eb_w = eb_w + 5'd1;
         eb_r = eb_r + 5'd1;
      end
      tick(1'b0, 1'b0);
      chk("st_end_lvl", bus.fill_level === 5'd5, bus.fill_level, 5);
      chk("st_end_wrg", bus.wr_ptr_gray === gray(5'd20), bus.wr_ptr_gray, gray(5'd20));

      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("er_empty", bus.empty === 1'b1, bus.empty, 1);
      chk("er_wren", bus.ram_wr_en === 1'b1, bus.ram_wr_en, 1);
      chk("er_rden", bus.ram_rd_en === 1'b0, bus.ram_rd_en, 0);
      tick(1'b0, 1'b0);
      chk("er_udf", bus.underflow === 1'b1, bus.underflow, 1);
      chk("er_lvl", bus.fill_level === 5'd1, bus.fill_level, 1);
      chk("er_empty2", bus.empty === 1'b0, bus.empty, 0);
      chk("er_rdv", bus.rd_valid === 1'b0, bus.rd_valid, 0);

      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("ar_lvl9", bus.fill_level === 5'd9, bus.fill_level, 9);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_lvl", bus.fill_level === 5'd0, bus.fill_level, 0);
      chk("ar_empty", bus.empty === 1'b1, bus.empty, 1);
      chk("ar_aempty", bus.almost_empty === 1'b1, bus.almost_empty, 1);
      chk("ar_full", bus.full === 1'b0, bus.full, 0);
      chk("ar_wrg", bus.wr_ptr_gray === 5'd0, bus.wr_ptr_gray, 0);
      chk("ar_rdg", bus.rd_ptr_gray === 5'd0, bus.rd_ptr_gray, 0);
      chk("ar_wraddr", bus.ram_wr_addr === 4'd0, bus.ram_wr_addr, 0);
      bus.wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick(1'b1, 1'b0);
      chk("ar_first_en", bus.ram_wr_en === 1'b1, bus.ram_wr_en, 1);
      chk("ar_first_addr", bus.ram_wr_addr === 4'd0, bus.ram_wr_addr, 0);
      tick(1'b0, 1'b0);
      chk("ar_first_lvl", bus.fill_level === 5'd1, bus.fill_level, 1);
      chk("ar_first_wrg", bus.wr_ptr_gray === 5'd1, bus.wr_ptr_gray, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
